// File: rtl/stopwatch_core_if.sv
// Stopwatch control/display interface.
// The master side drives the clock-generator inputs and the control pulses.
// The slave side is the stopwatch core, which returns status and the
// scanned seven-segment digit.
interface stopwatch_core_if;

  // Inputs to the core
  logic       clk_100;    // 100 Hz level from the clock generator, sampled as data
  logic [1:0] clk_ctl;    // display scan phase
  logic       start_p;    // start/pause toggle pulse
  logic       lap_p;      // lap freeze toggle pulse
  logic       clear_p;    // clear-to-zero pulse

  // Outputs from the core
  logic       running;    // high while the stopwatch is counting
  logic       lap_on;     // high while the display is frozen on the lap value
  logic [3:0] bcd_digit;  // BCD value of the scanned digit
  logic [3:0] ssd_ctl;    // active-low digit enables
  logic       dp_n;       // active-low decimal point

  modport master (
    output clk_100, clk_ctl, start_p, lap_p, clear_p,
    input  running, lap_on, bcd_digit, ssd_ctl, dp_n
  );

  modport slave (
    input  clk_100, clk_ctl, start_p, lap_p, clear_p,
    output running, lap_on, bcd_digit, ssd_ctl, dp_n
  );

endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch core: counts hundredths of seconds on rising edges of the
// 100 Hz level, under start/pause/clear/lap control, and scans one BCD
// digit per display phase (display format SS.CC).
// Everything runs on the crystal clock; clk_100 is only ever sampled.
module stopwatch_core #(
  parameter int unsigned MAX_SEC = 59   // highest seconds value before wrap, 1..99
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  sw
);

  // Seconds limit split into BCD tens/units for the wrap comparison.
  localparam logic [3:0] MAX_ST = 4'(MAX_SEC / 10);
  localparam logic [3:0] MAX_SU = 4'(MAX_SEC % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Four-digit BCD time value, seconds tens down to hundredths units.
  typedef struct packed {
    logic [3:0] st;   // seconds tens
    logic [3:0] su;   // seconds units
    logic [3:0] ct;   // hundredths tens
    logic [3:0] cu;   // hundredths units
  } bcd_time_t;

  state_t    state_q, state_d;
  logic      clk_100_q;
  bcd_time_t cnt_q, cnt_d;
  bcd_time_t lap_q;
  logic      lap_on_q;
  bcd_time_t disp;

  logic      tick;
  logic      clr_act, start_act, lap_act;
  logic      count_inc, count_clr, lap_toggle;

  logic [3:0] dig_q, dig_d;
  logic [3:0] ssd_q, ssd_d;
  logic       dp_q,  dp_d;

  // Rising edge of the 100 Hz level, one crystal cycle wide.
  assign tick = sw.clk_100 & ~clk_100_q;

  // Pulse priority: clear masks start and lap, start masks lap.
  assign clr_act   = sw.clear_p;
  assign start_act = sw.start_p & ~sw.clear_p;
  assign lap_act   = sw.lap_p & ~sw.start_p & ~sw.clear_p;

  // Datapath controls decoded from the current (registered) state, so a
  // tick that arrives together with start in IDLE is not counted, while
  // one that arrives with start in RUN is.
  assign count_inc  = tick && (state_q == RUN);
  assign count_clr  = clr_act && (state_q != RUN);
  assign lap_toggle = lap_act && (state_q == RUN);

  // State register and clk_100 history.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_100_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_100_q <= sw.clk_100;
    end
  end

  // Next-state logic for IDLE / RUN / PAUSE.
  // NOTE: each combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_act) state_d = RUN;
      RUN:     if (start_act) state_d = PAUSE;
      PAUSE: begin
        if (clr_act)        state_d = IDLE;
        else if (start_act) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: running is a pure decode of the state register.
  always_comb begin
    sw.running = (state_q == RUN);
  end

  // BCD ripple increment with wrap from MAX_SEC.99 to 00.00.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (count_inc) begin
      if (cnt_q.cu == 4'd9) begin
        cnt_d.cu = 4'd0;
        if (cnt_q.ct == 4'd9) begin
          cnt_d.ct = 4'd0;
          if (cnt_q.st == MAX_ST && cnt_q.su == MAX_SU) begin
            cnt_d.st = 4'd0;
            cnt_d.su = 4'd0;
          end else if (cnt_q.su == 4'd9) begin
            cnt_d.su = 4'd0;
            cnt_d.st = cnt_q.st + 4'd1;
          end else begin
            cnt_d.su = cnt_q.su + 4'd1;
          end
        end else begin
          cnt_d.ct = cnt_q.ct + 4'd1;
        end
      end else begin
        cnt_d.cu = cnt_q.cu + 4'd1;
      end
    end
  end

  // Live count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Lap freeze: toggle in RUN, capture the live count when turning on,
  // drop on clear from IDLE or PAUSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_on_q <= 1'b0;
      lap_q    <= '0;
    end else if (count_clr) begin
      lap_on_q <= 1'b0;
    end else if (lap_toggle) begin
      lap_on_q <= ~lap_on_q;
      if (!lap_on_q) lap_q <= cnt_q;
    end
  end

  assign sw.lap_on = lap_on_q;

  // Display source: frozen lap value while lap is on, else the live count.
  assign disp = lap_on_q ? lap_q : cnt_q;

  // Digit select, enable pattern and decimal point for the scan phase.
  always_comb begin
    dig_d = disp.cu;
    ssd_d = 4'b1110;
    dp_d  = 1'b1;
    unique case (sw.clk_ctl)
      2'b00: begin dig_d = disp.cu; ssd_d = 4'b1110; dp_d = 1'b1; end
      2'b01: begin dig_d = disp.ct; ssd_d = 4'b1101; dp_d = 1'b1; end
      2'b10: begin dig_d = disp.su; ssd_d = 4'b1011; dp_d = 1'b0; end
      2'b11: begin dig_d = disp.st; ssd_d = 4'b0111; dp_d = 1'b1; end
    endcase
  end

  // Registered scan outputs, one cycle behind clk_ctl; all digits off in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= 4'd0;
      ssd_q <= 4'b1111;
      dp_q  <= 1'b1;
    end else begin
      dig_q <= dig_d;
      ssd_q <= ssd_d;
      dp_q  <= dp_d;
    end
  end

  assign sw.bcd_digit = dig_q;
  assign sw.ssd_ctl   = ssd_q;
  assign sw.dp_n      = dp_q;

endmodule
